// File: rtl/md4_compress_core.sv
// Iterative MD4 compression core performing UNROLL steps per clock (IDLE/RUN/DONE).
// Define MD4_FEEDFORWARD_EN to add the latched chaining input to the final state.
module md4_compress_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] blk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [5:0] STEP_INC  = 6'(UNROLL);
  localparam logic [5:0] LAST_STEP = 6'(48 - UNROLL);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("md4_compress_core: UNROLL must be 1, 2 or 4");
    end
  endgenerate

  // Each shift amount is a constant wire permutation; the step selects one.
  function automatic logic [31:0] rotl_fixed(input logic [31:0] v, input logic [4:0] s);
    logic [31:0] r;
    case (s)
      5'd3:    r = {v[28:0], v[31:29]};
      5'd5:    r = {v[26:0], v[31:27]};
      5'd7:    r = {v[24:0], v[31:25]};
      5'd9:    r = {v[22:0], v[31:23]};
      5'd11:   r = {v[20:0], v[31:21]};
      5'd13:   r = {v[18:0], v[31:19]};
      5'd15:   r = {v[16:0], v[31:17]};
      5'd19:   r = {v[12:0], v[31:13]};
      default: r = v;
    endcase
    return r;
  endfunction

  // One step on {a,b,c,d}; the result is re-packed so the next target is always in slot a.
  function automatic logic [127:0] md4_step(input logic [127:0] st, input logic [5:0] idx,
                                            input logic [511:0] x);
    logic [31:0] a, b, c, d, f, k, w;
    logic [3:0]  j, wi;
    logic [4:0]  s;
    {a, b, c, d} = st;
    j = idx[3:0];
    case (idx[5:4])
      2'd0: begin
        f  = (b & c) | (~b & d);
        k  = 32'h0000_0000;
        wi = j;
        case (j[1:0])
          2'd0: s = 5'd3;
          2'd1: s = 5'd7;
          2'd2: s = 5'd11;
          default: s = 5'd19;
        endcase
      end
      2'd1: begin
        f  = (b & c) | (b & d) | (c & d);
        k  = 32'h5A82_7999;
        wi = {j[1:0], j[3:2]};
        case (j[1:0])
          2'd0: s = 5'd3;
          2'd1: s = 5'd5;
          2'd2: s = 5'd9;
          default: s = 5'd13;
        endcase
      end
      default: begin
        f  = b ^ c ^ d;
        k  = 32'h6ED9_EBA1;
        wi = {j[0], j[1], j[2], j[3]};
        case (j[1:0])
          2'd0: s = 5'd3;
          2'd1: s = 5'd9;
          2'd2: s = 5'd11;
          default: s = 5'd15;
        endcase
      end
    endcase
    w = x[{wi, 5'd0} +: 32];
    return {d, rotl_fixed(a + f + w + k, s), b, c};
  endfunction

  state_t         state_q, state_d;
  logic [5:0]     step_q, step_d;
  logic [127:0]   work_q, work_d;
  logic [511:0]   x_q, x_d;
  logic [127:0]   out_q, out_d;
  logic [127:0]   chain [0:UNROLL];
  logic [127:0]   result;

  assign chain[0] = work_q;

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [5:0] step_idx;
      assign step_idx     = step_q + 6'(gi);
      assign chain[gi + 1] = md4_step(chain[gi], step_idx, x_q);
    end
  endgenerate

`ifdef MD4_FEEDFORWARD_EN
  logic [127:0] iv_q, iv_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      result[32*i +: 32] = chain[UNROLL][32*i +: 32] + iv_q[32*i +: 32];
    end
  end
`else
  assign result = chain[UNROLL];
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    work_d  = work_q;
    x_d     = x_q;
    out_d   = out_q;
`ifdef MD4_FEEDFORWARD_EN
    iv_d    = iv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = {a_in, b_in, c_in, d_in};
          x_d     = blk;
          step_d  = 6'd0;
          state_d = RUN;
`ifdef MD4_FEEDFORWARD_EN
          iv_d    = {a_in, b_in, c_in, d_in};
`endif
        end
      end
      RUN: begin
        work_d = chain[UNROLL];
        step_d = step_q + STEP_INC;
        if (step_q == LAST_STEP) begin
          out_d   = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 6'd0;
      work_q  <= '0;
      x_q     <= '0;
      out_q   <= '0;
`ifdef MD4_FEEDFORWARD_EN
      iv_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
      x_q     <= x_d;
      out_q   <= out_d;
`ifdef MD4_FEEDFORWARD_EN
      iv_q    <= iv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign {a_out, b_out, c_out, d_out} = out_q;
endmodule

// File: tb/tb_md4_compress_core.sv
// Randomized self-checking bench for md4_compress_core against a plain MD4 reference model.
`timescale 1ns/1ps
module tb_md4_compress_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [511:0] blk;
  logic         in_ready, out_valid, busy;
  logic [31:0]  a_out, b_out, c_out, d_out;

  logic         v2, v4, ur_x;
  logic         ir2, ir4, ov2, ov4, bz2, bz4;
  logic [31:0]  a2, b2, c2, d2, a4, b4, c4, d4;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rand_or = 1'b0;

  md4_compress_core #(.UNROLL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .blk(blk),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out), .busy(busy));

  md4_compress_core #(.UNROLL(2)) dut_u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .blk(blk),
    .out_valid(ov2), .out_ready(ur_x),
    .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2), .busy(bz2));

  md4_compress_core #(.UNROLL(4)) dut_u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .blk(blk),
    .out_valid(ov4), .out_ready(ur_x),
    .a_out(a4), .b_out(b4), .c_out(c4), .d_out(d4), .busy(bz4));

  localparam logic [127:0] IV        = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] EMPTY_LIT = 128'he0cfd631_31e96ad1_d7593cb7_c089c0e0;
  localparam logic [127:0] ABC_LIT   = 128'h7a0148a4_52d821af_e80ac15f_9d72a67a;

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // Reference MD4: the state array is indexed directly; target order a,d,c,b.
  function automatic logic [127:0] md4_work(input logic [127:0] iv, input logic [511:0] m);
    logic [31:0] h [4];
    logic [31:0] xw [16];
    int r2 [16];
    int r3 [16];
    int sh [3][4];
    logic [31:0] kc [3];
    r2 = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    r3 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    sh = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
    kc = '{32'h0, 32'h5A827999, 32'h6ED9EBA1};
    h[0] = iv[127:96]; h[1] = iv[95:64]; h[2] = iv[63:32]; h[3] = iv[31:0];
    for (int j = 0; j < 16; j++) xw[j] = m[32*j +: 32];
    for (int i = 0; i < 48; i++) begin
      int r, j, t, k;
      logic [31:0] x, y, z, f;
      r = i / 16; j = i % 16; t = (4 - (i % 4)) % 4;
      x = h[(t + 1) % 4]; y = h[(t + 2) % 4]; z = h[(t + 3) % 4];
      if (r == 0) begin f = (x & y) | (~x & z); k = j; end
      else if (r == 1) begin f = (x & y) | (x & z) | (y & z); k = r2[j]; end
      else begin f = x ^ y ^ z; k = r3[j]; end
      h[t] = rl(h[t] + f + xw[k] + kc[r], sh[r][j % 4]);
    end
    return {h[0], h[1], h[2], h[3]};
  endfunction

  function automatic logic [127:0] addw(input logic [127:0] p, input logic [127:0] q);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = p[32*i +: 32] + q[32*i +: 32];
    return r;
  endfunction

  function automatic logic [127:0] subw(input logic [127:0] p, input logic [127:0] q);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = p[32*i +: 32] - q[32*i +: 32];
    return r;
  endfunction

  function automatic logic [127:0] expect_out(input logic [127:0] iv, input logic [511:0] m);
`ifdef MD4_FEEDFORWARD_EN
    return addw(md4_work(iv, m), iv);
`else
    return md4_work(iv, m);
`endif
  endfunction

  function automatic logic [127:0] lit_exp(input logic [127:0] lit);
`ifdef MD4_FEEDFORWARD_EN
    return lit;
`else
    return subw(lit, IV);
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Transaction-level timing model of the main DUT.
  int           m_state = 0;
  int           m_cnt = 0;
  logic [127:0] m_out = '0, m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0; m_cnt <= 0; m_out <= '0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_state <= 1; m_cnt <= 47;
          m_pend  <= expect_out({a_in, b_in, c_in, d_in}, blk);
        end
        1: if (m_cnt == 0) begin m_state <= 2; m_out <= m_pend; end
           else m_cnt <= m_cnt - 1;
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_in_ready", 128'(in_ready), 128'(m_state == 0));
      chk("mon_busy", 128'(busy), 128'(m_state != 0));
      chk("mon_out_valid", 128'(out_valid), 128'(m_state == 2));
      chk("mon_outputs", {a_out, b_out, c_out, d_out}, m_out);
    end
  end

  always @(negedge clk) if (rand_or) out_ready = 1'($urandom_range(0, 1));

  task automatic wait_for(input int sel, input logic val, input string nm);
    int n = 0;
    logic s;
    forever begin
      case (sel)
        0: s = busy;
        1: s = out_valid;
        default: s = in_ready;
      endcase
      if (s === val || n >= 400) break;
      @(negedge clk); n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL timeout_%s actual=no_event required=event_within_400_cycles", nm);
    end
  endtask

  task automatic send(input logic [127:0] iv, input logic [511:0] m);
    {a_in, b_in, c_in, d_in} = iv; blk = m; in_valid = 1'b1;
    wait_for(2, 1'b1, "send");
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  logic [511:0] empty_blk, abc_blk, rb1, rb2;
  logic [127:0] riv1, riv2;
  int lat, lat2, lat4;

  initial begin
    empty_blk = '0; empty_blk[31:0] = 32'h00000080;
    abc_blk = '0; abc_blk[31:0] = 32'h80636261; abc_blk[14*32 +: 32] = 32'h00000018;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; v2 = 1'b0; v4 = 1'b0; ur_x = 1'b1;
    {a_in, b_in, c_in, d_in} = '0; blk = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_outputs", {a_out, b_out, c_out, d_out}, 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_in_ready", 128'(in_ready), 128'h1);

    chk("model_empty", addw(md4_work(IV, empty_blk), IV), EMPTY_LIT);
    chk("model_abc", addw(md4_work(IV, abc_blk), IV), ABC_LIT);

    // Empty message, then backpressure in DONE.
    send(IV, empty_blk);
    wait_done(lat);
    $display("txn empty latency=%0d out=%h", lat, {a_out, b_out, c_out, d_out});
    chk("empty_latency", 128'(lat), 128'd48);
    chk("empty_out", {a_out, b_out, c_out, d_out}, lit_exp(EMPTY_LIT));
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        blk = {16{$urandom}}; {a_in, b_in, c_in, d_in} = {4{$urandom}}; in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'h0);
      chk("bp_hold", {a_out, b_out, c_out, d_out}, lit_exp(EMPTY_LIT));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'h1);
    $display("txn backpressure released");

    // Reset pulse at step 20, then "abc".
    send(IV, abc_blk);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_in_ready", 128'(in_ready), 128'h1);
    chk("midrst_outputs", {a_out, b_out, c_out, d_out}, 128'h0);
    rst = 1'b0;
    send(IV, abc_blk);
    wait_done(lat);
    $display("txn abc latency=%0d out=%h", lat, {a_out, b_out, c_out, d_out});
    chk("abc_latency", 128'(lat), 128'd48);
    chk("abc_out", {a_out, b_out, c_out, d_out}, lit_exp(ABC_LIT));

    // Back-to-back with in_valid held high.
    riv1 = {4{$urandom}}; riv2 = {4{$urandom}};
    for (int i = 0; i < 16; i++) begin rb1[32*i +: 32] = $urandom; rb2[32*i +: 32] = $urandom; end
    wait_for(0, 1'b0, "b2b_idle");
    {a_in, b_in, c_in, d_in} = riv1; blk = rb1; in_valid = 1'b1;
    wait_for(0, 1'b1, "b2b_accept1");
    {a_in, b_in, c_in, d_in} = riv2; blk = rb2;
    wait_for(1, 1'b1, "b2b_done1");
    chk("b2b_first", {a_out, b_out, c_out, d_out}, expect_out(riv1, rb1));
    $display("txn b2b first out=%h", {a_out, b_out, c_out, d_out});
    wait_for(0, 1'b0, "b2b_idle2");
    wait_for(0, 1'b1, "b2b_accept2");
    in_valid = 1'b0;
    wait_for(1, 1'b1, "b2b_done2");
    chk("b2b_second", {a_out, b_out, c_out, d_out}, expect_out(riv2, rb2));
    $display("txn b2b second out=%h", {a_out, b_out, c_out, d_out});

    // Random blocks with random consumer stalls; the monitor checks every cycle.
    rand_or = 1'b1;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 16; i++) rb1[32*i +: 32] = $urandom;
      riv1 = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(riv1, rb1);
      $display("txn random %0d iv=%h", t, riv1);
    end
    wait_for(0, 1'b0, "random_drain");
    rand_or = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

    // Unrolled variants on "abc".
    chk("u2_idle", 128'(ir2), 128'h1);
    chk("u4_idle", 128'(ir4), 128'h1);
    {a_in, b_in, c_in, d_in} = IV; blk = abc_blk; v2 = 1'b1; v4 = 1'b1;
    @(negedge clk);
    v2 = 1'b0; v4 = 1'b0;
    lat2 = -1; lat4 = -1;
    for (int n = 0; n < 60; n++) begin
      if (ov2 && lat2 < 0) begin lat2 = n; chk("u2_out", {a2, b2, c2, d2}, lit_exp(ABC_LIT)); end
      if (ov4 && lat4 < 0) begin lat4 = n; chk("u4_out", {a4, b4, c4, d4}, lit_exp(ABC_LIT)); end
      @(negedge clk);
    end
    $display("txn unroll latencies u2=%0d u4=%0d", lat2, lat4);
    chk("u2_latency", 128'(lat2), 128'd24);
    chk("u4_latency", 128'(lat4), 128'd12);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=still_running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
